bus_protocol_initiator: RTL and testbench
=========================================

# bus_protocol_initiator

Single-outstanding initiator for `bus_protocol_if`: it drives the bus as the requester, where the register-map side is the responder. Accepts one command at a time on a valid/ready request channel, drives `addr/wdata/strobe/wen/ren`, and holds the access while `request_stall` is high. Returns `rdata`/`error` on a valid/ready response channel. Used by the USI DMA/sequencer logic and as the driving side for register-map integration benches.

## Interface
- `TIMEOUT_CYCLES`, 16: stalled-access cycles before abort; must be ≥1; only used with `BUS_INIT_TIMEOUT_EN`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: command present.
- `req_ready` out 1: command accepted when high with `req_valid`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `req_strobe` in 4: byte enables; bit i covers `wdata[8i+7:8i]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high with `rsp_valid`.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_error` out 1: responder `error`, or timeout.
- `rsp_timeout` out 1: access aborted by timeout.
- `bpif` interface, initiator side: drives `addr, wdata, strobe, wen, ren`; samples `rdata, error, request_stall`.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, capture write/addr/wdata/strobe and go to ACCESS.
- **ACCESS**
  - `wen` = captured write; `ren` = !captured write.
  - `addr`, `wdata` and `strobe` come from the captured registers and are stable for the whole access.
  - Each edge where `request_stall` = 0: capture `rdata` (reads only, else 0) and `error`, then go to RESP.
  - While `request_stall` = 1: stay in ACCESS with all outputs unchanged.
- **RESP**
  - `rsp_valid` = 1 and response fields are held.
  - On `rsp_ready`, go to IDLE.
- `wen`/`ren` are high only in ACCESS and never both high.
- Outside ACCESS, `addr/wdata/strobe` hold their last values.
- A write with `strobe` = 0 is still issued on the bus.
- Reads drive the captured strobe unchanged.
- A new request is never accepted while a response is pending; there is exactly one outstanding transaction.
- Reset state:
  - state IDLE;
  - `wen`=`ren`=0; `addr`=`wdata`=0; `strobe`=0;
  - `rsp_valid`=0; `rsp_rdata`=0; `rsp_error`=0; `rsp_timeout`=0.
  - `req_ready` = 1 (decoded from IDLE).
- Reset mid-access: bus enables drop asynchronously and the in-flight transaction and pending response are discarded.

## Timing
- Request accepted at edge k. Bus enables are valid from just after edge k through edge k+1+S, where S is the number of cycles `request_stall` is sampled high.
- Response is captured at edge k+1+S. `rsp_valid` rises after that edge.
- With `rsp_ready` held high, `req_ready` returns after edge k+2+S.
- Minimum spacing is 3 cycles per transaction.
- Request/response fields are sampled only on the handshake edge. Changes on `req_*` at other times have no effect.

## Configuration
- `BUS_INIT_TIMEOUT_EN` defined:
  - A counter (width `$clog2(TIMEOUT_CYCLES+1)`) clears on entry to ACCESS and increments each stalled cycle.
  - When it reaches `TIMEOUT_CYCLES`, the access aborts: enables drop and the FSM goes to RESP with `rsp_error`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- Undefined:
  - No counter is built; ACCESS waits indefinitely.
  - `rsp_timeout` is tied to 0 and `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `usi_bus_pkg`: FSM state enum `bus_init_state_t`, packed `bus_req_t` (write, addr, wdata, strobe), packed `bus_rsp_t` (rdata, error, timeout), `BUS_ADDR_W`=32, `BUS_DATA_W`=32.
- One sub-module `bus_timeout_counter`: inputs clear/enable, output `expired`. It is instantiated only under `BUS_INIT_TIMEOUT_EN`.

## Test plan
- Write 0x12345678 to addr 0x4 with strobe 0xF (register-map responder, no stall) -> `wen` high for exactly 1 cycle, `rsp_error`=0; a following read of 0x4 returns `rsp_rdata`=0x12345678.
- Write 0xFFFF0000 to 0x4 with strobe 0x3, then read 0x4 -> `rsp_rdata`=0x12340000.
- Write to unmapped addr 0x20 -> `rsp_error`=1, `rsp_timeout`=0.
- Stub responder holds `request_stall` for 5 cycles on a read returning 0xCAFEF00D -> bus fields stable for 6 cycles, then `rsp_rdata`=0xCAFEF00D.
- Hold `rsp_ready`=0 for 4 cycles -> `rsp_valid` and fields held, `req_ready`=0 throughout; then one-cycle handshake and return to IDLE.
- With `BUS_INIT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, a permanent stall -> enables drop after 16 stalled cycles, `rsp_error`=`rsp_timeout`=1. Separately, assert `nRST` mid-access -> `wen`/`ren` go to 0 immediately and no response is produced.

Source files
------------

// File: rtl/usi_bus_pkg.sv
// Shared types and widths for the USI bus initiator and its bus interface.
package usi_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_init_state_t;

    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_STRB_W-1:0] strobe;
    } bus_req_t;

    typedef struct packed {
        logic [BUS_DATA_W-1:0] rdata;
        logic                  error;
        logic                  timeout;
    } bus_rsp_t;

endpackage

// File: rtl/bus_protocol_if.sv
// Register-map bus between one requester (initiator) and the register-map responder.
interface bus_protocol_if;
    import usi_bus_pkg::*;

    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] strobe;
    logic                  wen;
    logic                  ren;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  error;
    logic                  request_stall;

    modport initiator (
        output addr, wdata, strobe, wen, ren,
        input  rdata, error, request_stall
    );

    modport responder (
        input  addr, wdata, strobe, wen, ren,
        output rdata, error, request_stall
    );

endinterface

// File: rtl/bus_timeout_counter.sv
// Counts stalled access cycles; expired fires on the stalled cycle that reaches TIMEOUT_CYCLES.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // The count reaches TIMEOUT_CYCLES on the same edge the access aborts.
    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_protocol_initiator.sv
// Single-outstanding bus_protocol_if requester with valid/ready command and response channels.
// Optional stall timeout is built when BUS_INIT_TIMEOUT_EN is defined.
module bus_protocol_initiator
    import usi_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [BUS_ADDR_W-1:0] req_addr,
    input  logic [BUS_DATA_W-1:0] req_wdata,
    input  logic [BUS_STRB_W-1:0] req_strobe,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    bus_protocol_if.initiator     bpif
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bus_init_state_t state_q, state_d;
    bus_req_t        req_q, req_d;
    bus_rsp_t        rsp_q, rsp_d;
    logic            wen_q, wen_d;
    logic            ren_q, ren_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            req_ready_q, req_ready_d;
    logic            timeout_c;

`ifdef BUS_INIT_TIMEOUT_EN
    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (state_q == ST_IDLE),
        .enable  ((state_q == ST_ACCESS) && bpif.request_stall),
        .expired (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        wen_d       = wen_q;
        ren_d       = ren_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d     = ST_ACCESS;
                    req_d       = '{write: req_write, addr: req_addr,
                                    wdata: req_wdata, strobe: req_strobe};
                    wen_d       = req_write;
                    ren_d       = !req_write;
                    req_ready_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (!bpif.request_stall) begin
                    state_d     = ST_RESP;
                    wen_d       = 1'b0;
                    ren_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{rdata: req_q.write ? '0 : bpif.rdata,
                                    error: bpif.error, timeout: 1'b0};
                end else if (timeout_c) begin
                    state_d     = ST_RESP;
                    wen_d       = 1'b0;
                    ren_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{rdata: '0, error: 1'b1, timeout: 1'b1};
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                wen_d       = 1'b0;
                ren_d       = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bpif.addr   = req_q.addr;
    assign bpif.wdata  = req_q.wdata;
    assign bpif.strobe = req_q.strobe;
    assign bpif.wen    = wen_q;
    assign bpif.ren    = ren_q;

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_bus_protocol_initiator.sv
// Bench for bus_protocol_initiator: register-map responder stub plus a word-level expected memory.
// The stall-timeout step runs only when BUS_INIT_TIMEOUT_EN is defined.
module tb_bus_protocol_initiator;

    logic        CLK;
    logic        nRST;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strobe;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;

    bus_protocol_if bpif ();

    bus_protocol_initiator #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strobe  (req_strobe),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .bpif        (bpif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Responder stub: eight words at 0x00..0x1C, everything above is unmapped.
    logic [31:0] rsp_mem [8];
    logic        mem_clr;
    logic        stub_en;
    logic [31:0] stub_data;
    logic        mapped_c;

    always_comb begin
        mapped_c   = (bpif.addr < 32'h20);
        bpif.rdata = 32'h0;
        bpif.error = 1'b0;
        if (bpif.ren) bpif.rdata = stub_en ? stub_data : (mapped_c ? rsp_mem[bpif.addr[4:2]] : 32'h0);
        if (bpif.wen || bpif.ren) bpif.error = stub_en ? 1'b0 : !mapped_c;
    end

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) rsp_mem[i] <= 32'h0;
        end else if (bpif.wen && !bpif.request_stall && mapped_c && !stub_en) begin
            for (int b = 0; b < 4; b++)
                if (bpif.strobe[b]) rsp_mem[bpif.addr[4:2]][8*b +: 8] <= bpif.wdata[8*b +: 8];
        end
    end

    // Expected register contents, tracked per word.
    logic [31:0] exp_mem [8];

    task automatic model_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] erd, output logic eerr);
        logic [31:0] mask;
        int          w;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        w    = int'(a / 4);
        erd  = 32'h0;
        eerr = (a >= 32'h20);
        if (!eerr && wr)  exp_mem[w] = (exp_mem[w] & ~mask) | (d & mask);
        if (!eerr && !wr) erd = exp_mem[w];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge with req_ready expected high.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int stall, input int hold,
                           input logic [31:0] erd, input logic eerr);
        int wen_cycles;
        check("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = d;
        req_strobe = s;
        @(posedge CLK);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_strobe = 4'($urandom);
        wen_cycles = 0;
        for (int i = 0; i <= stall; i++) begin
            @(negedge CLK);
            bpif.request_stall = (i < stall);
            if (bpif.wen) wen_cycles++;
            check("bus_wen", bpif.wen, wr);
            check("bus_ren", bpif.ren, !wr);
            check("bus_addr", bpif.addr, a);
            check("bus_wdata", bpif.wdata, d);
            check("bus_strobe", bpif.strobe, s);
            check("rsp_valid_access", rsp_valid, 1'b0);
            check("req_ready_access", req_ready, 1'b0);
        end
        @(negedge CLK);
        bpif.request_stall = 1'b0;
        check("wen_cycles", wen_cycles, wr ? stall + 1 : 0);
        check("wen_after", bpif.wen, 1'b0);
        check("ren_after", bpif.ren, 1'b0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge CLK);
            check("rsp_valid", rsp_valid, 1'b1);
            check("req_ready_resp", req_ready, 1'b0);
            check("rsp_rdata", rsp_rdata, erd);
            check("rsp_error", rsp_error, eerr);
            check("rsp_timeout", rsp_timeout, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check("rsp_valid_done", rsp_valid, 1'b0);
        check("req_ready_done", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] erd;
        logic        eerr;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;
        nRST               = 1'b0;
        mem_clr            = 1'b1;
        stub_en            = 1'b0;
        stub_data          = 32'h0;
        req_valid          = 1'b0;
        req_write          = 1'b0;
        req_addr           = 32'h0;
        req_wdata          = 32'h0;
        req_strobe         = 4'h0;
        rsp_ready          = 1'b0;
        bpif.request_stall = 1'b0;
        repeat (2) @(negedge CLK);

        check("reset_wen", bpif.wen, 1'b0);
        check("reset_ren", bpif.ren, 1'b0);
        check("reset_addr", bpif.addr, 32'h0);
        check("reset_wdata", bpif.wdata, 32'h0);
        check("reset_strobe", bpif.strobe, 4'h0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_error", rsp_error, 1'b0);
        check("reset_rsp_timeout", rsp_timeout, 1'b0);
        check("reset_req_ready", req_ready, 1'b1);

        nRST    = 1'b1;
        mem_clr = 1'b0;
        @(negedge CLK);

        // Full write, read back, partial write, read back.
        model_txn(1'b1, 32'h4, 32'h12345678, 4'hF, erd, eerr);
        run_txn(1'b1, 32'h4, 32'h12345678, 4'hF, 0, 0, 32'h0, 1'b0);
        model_txn(1'b0, 32'h4, 32'h0, 4'hF, erd, eerr);
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 0, 32'h12345678, 1'b0);
        model_txn(1'b1, 32'h4, 32'hFFFF0000, 4'h3, erd, eerr);
        run_txn(1'b1, 32'h4, 32'hFFFF0000, 4'h3, 0, 0, 32'h0, 1'b0);
        model_txn(1'b0, 32'h4, 32'h0, 4'h3, erd, eerr);
        run_txn(1'b0, 32'h4, 32'h0, 4'h3, 0, 0, 32'h12340000, 1'b0);

        // Unmapped write, zero-strobe write still issued.
        run_txn(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h0, 1'b1);
        model_txn(1'b1, 32'h8, 32'h55AA55AA, 4'h0, erd, eerr);
        run_txn(1'b1, 32'h8, 32'h55AA55AA, 4'h0, 0, 0, 32'h0, 1'b0);

        // Stub responder stalls a read for five cycles.
        stub_en   = 1'b1;
        stub_data = 32'hCAFEF00D;
        run_txn(1'b0, 32'h10, 32'h0, 4'h5, 5, 0, 32'hCAFEF00D, 1'b0);
        stub_en   = 1'b0;

        // Response held back for four cycles.
        model_txn(1'b0, 32'h4, 32'h0, 4'hF, erd, eerr);
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 1, 4, 32'h12340000, 1'b0);

        // Random traffic against the expected memory.
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom);
            a  = 32'($urandom_range(0, 9) * 4);
            d  = $urandom;
            s  = 4'($urandom);
            model_txn(wr, a, d, s, erd, eerr);
            run_txn(wr, a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), erd, eerr);
        end

`ifdef BUS_INIT_TIMEOUT_EN
        // Permanent stall: access aborts after 16 stalled cycles.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h4;
        req_strobe = 4'hF;
        @(posedge CLK);
        #1;
        req_valid          = 1'b0;
        bpif.request_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            check("tmo_ren_held", bpif.ren, 1'b1);
            check("tmo_no_rsp", rsp_valid, 1'b0);
        end
        @(negedge CLK);
        check("tmo_ren_drop", bpif.ren, 1'b0);
        check("tmo_rsp_valid", rsp_valid, 1'b1);
        check("tmo_rsp_error", rsp_error, 1'b1);
        check("tmo_rsp_timeout", rsp_timeout, 1'b1);
        check("tmo_rsp_rdata", rsp_rdata, 32'h0);
        bpif.request_stall = 1'b0;
        rsp_ready          = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check("tmo_req_ready", req_ready, 1'b1);
`endif

        // Reset in the middle of a stalled read.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'hC;
        req_strobe = 4'hF;
        @(posedge CLK);
        #1;
        req_valid          = 1'b0;
        bpif.request_stall = 1'b1;
        @(negedge CLK);
        check("rst_ren_before", bpif.ren, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        check("rst_ren_async", bpif.ren, 1'b0);
        check("rst_wen_async", bpif.wen, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        @(negedge CLK);
        nRST               = 1'b1;
        bpif.request_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_no_rsp", rsp_valid, 1'b0);
            check("post_rst_ren", bpif.ren, 1'b0);
            check("post_rst_ready", req_ready, 1'b1);
        end

        // Bus still usable after the abort.
        model_txn(1'b0, 32'h4, 32'h0, 4'hF, erd, eerr);
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 0, erd, eerr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
